// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: request sizes and FSM states.
package mau_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: extract/extend load data and merge sub-word store data.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data_c,
  output logic [DATA_W-1:0] st_data_c
);

  logic [4:0]  byte_base;
  logic [4:0]  half_base;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_base = {offset, 3'b000};
  assign half_base = {offset[1], 4'b0000};
  assign byte_lane = rdata[byte_base +: 8];
  assign half_lane = rdata[half_base +: 16];

  // Load path: pick the addressed lane and extend it to a full word.
  always_comb begin
    ld_data_c = rdata;
    case (size)
      SZ_BYTE: ld_data_c = sgn ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      SZ_HALF: ld_data_c = sgn ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      default: ld_data_c = rdata;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    st_data_c = rdata;
    case (size)
      SZ_BYTE: st_data_c[byte_base +: 8]  = wdata[7:0];
      SZ_HALF: st_data_c[half_base +: 16] = wdata[15:0];
      SZ_WORD: st_data_c = wdata;
      default: st_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine for a word-addressed RAM with negedge write commit;
// sub-word stores are performed as read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_WORDS);

  state_e            state;
  size_e             size_q;
  logic [1:0]        off_q;
  logic              sgn_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_err_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] st_data_c;

  // Decoded straight from the state register so both are glitch-free and
  // mem_we falls together with an asynchronous reset.
  assign req_ready = (state == IDLE);
  assign mem_we    = (state == WR);

  // Reject illegal size, misalignment and out-of-range before touching the RAM.
  always_comb begin
    req_err_c = 1'b0;
    case (size_e'(req_size))
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = |req_addr[1:0];
      SZ_ILL:  req_err_c = 1'b1;
      default: req_err_c = 1'b0;
    endcase
    if (req_addr >= ADDR_LIMIT) req_err_c = 1'b1;
  end

  mau_lane_align u_lane_align (
    .offset    (off_q),
    .size      (size_q),
    .sgn       (sgn_q),
    .rdata     (mem_rdata),
    .wdata     (wdata_q),
    .ld_data_c (ld_data_c),
    .st_data_c (st_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      sgn_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= size_e'(req_size);
            off_q   <= req_addr[1:0];
            sgn_q   <= req_signed;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_err_c) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (we_q) begin
            mem_wdata <= st_data_c;
            state     <= WR;
          end else begin
            resp_rdata <= ld_data_c;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural negedge-write RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wes;
  } req_t;

  req_t sb[$];

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[11:2]];
  always @(negedge clk) if (mem_we === 1'b1) ram[mem_addr[11:2]] <= mem_wdata;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic drive(input req_t r);
    req_valid = 1'b1; req_we = r.we; req_size = r.size; req_signed = r.sgn;
    req_addr = r.addr; req_wdata = r.wdata;
  endtask

  // Drives one request, then scrambles req_* and observes the response.
  task automatic run_req(input req_t r, output logic [31:0] o_rdata, output logic o_err,
                         output int o_lat, output int o_wes, output logic o_clean);
    @(negedge clk);
    drive(r);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b1; req_size = 2'($urandom); req_signed = ~r.sgn;
    req_addr = $urandom; req_wdata = $urandom;
    o_lat = 1; o_wes = 0;
    while (resp_valid !== 1'b1 && o_lat < 12) begin
      if (mem_we === 1'b1) o_wes++;
      @(posedge clk); #1;
      o_lat++;
    end
    o_rdata = resp_rdata; o_err = resp_err;
    @(posedge clk); #1;
    o_clean = (resp_valid === 1'b0) && (resp_err === 1'b0) && (resp_rdata === 32'h0)
              && (req_ready === 1'b1) && (mem_we === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset resp_err got=%b exp=0", resp_err); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset resp_rdata got=%h exp=0", resp_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset mem_wdata got=%h exp=0", mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_loads;
    req_t t[9];
    req_t e;
    logic [31:0] rd; logic er, cl; int lat, wes;
    ram[2] = 32'h80F17F04;
    t[0] = '{1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 1'b0, 32'h00000004, 2, 0};
    t[1] = '{1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0, 32'h0000007F, 2, 0};
    t[2] = '{1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 1'b0, 32'hFFFFFFF1, 2, 0};
    t[3] = '{1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 1'b0, 32'hFFFFFF80, 2, 0};
    t[4] = '{1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 1'b0, 32'h00000080, 2, 0};
    t[5] = '{1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 1'b0, 32'hFFFF80F1, 2, 0};
    t[6] = '{1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 1'b0, 32'h000080F1, 2, 0};
    t[7] = '{1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 1'b0, 32'h00007F04, 2, 0};
    t[8] = '{1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 1'b0, 32'h80F17F04, 2, 0};
    foreach (t[i]) begin
      sb.push_back(t[i]);
      run_req(t[i], rd, er, lat, wes, cl);
      e = sb.pop_front();
      total++; if (er !== e.err) begin bad++; $display("FAIL load[%0d] err got=%b exp=%b", i, er, e.err); end
      total++; if (rd !== e.rdata) begin bad++; $display("FAIL load[%0d] rdata got=%h exp=%h", i, rd, e.rdata); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL load[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
      total++; if (wes !== e.wes) begin bad++; $display("FAIL load[%0d] we_cycles got=%0d exp=%0d", i, wes, e.wes); end
      total++; if (cl !== 1'b1) begin bad++; $display("FAIL load[%0d] pulse_clear got=%b exp=1", i, cl); end
    end
  endtask

  task automatic test_stores;
    req_t t[3];
    req_t e;
    logic [31:0] rd; logic er, cl; int lat, wes;
    logic [31:0] exp_ram [3];
    int          exp_idx [3];
    ram[4] = 32'h0;
    t[0] = '{1'b1, 2'b00, 1'b0, 32'h9,  32'h000000AA, 1'b0, 32'h0, 3, 1};
    t[1] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1};
    t[2] = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b0, 32'h0, 3, 1};
    exp_ram = '{32'h80F1AA04, 32'hDEADBEEF, 32'h1234BEEF};
    exp_idx = '{2, 4, 4};
    foreach (t[i]) begin
      sb.push_back(t[i]);
      run_req(t[i], rd, er, lat, wes, cl);
      e = sb.pop_front();
      total++; if (er !== e.err) begin bad++; $display("FAIL store[%0d] err got=%b exp=%b", i, er, e.err); end
      total++; if (rd !== e.rdata) begin bad++; $display("FAIL store[%0d] rdata got=%h exp=%h", i, rd, e.rdata); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL store[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
      total++; if (wes !== e.wes) begin bad++; $display("FAIL store[%0d] we_cycles got=%0d exp=%0d", i, wes, e.wes); end
      total++; if (cl !== 1'b1) begin bad++; $display("FAIL store[%0d] pulse_clear got=%b exp=1", i, cl); end
      total++; if (ram[exp_idx[i]] !== exp_ram[i]) begin
        bad++; $display("FAIL store[%0d] ram got=%h exp=%h", i, ram[exp_idx[i]], exp_ram[i]);
      end
    end
  endtask

  task automatic test_errors;
    req_t t[4];
    req_t e;
    logic [31:0] rd; logic er, cl; int lat, wes;
    logic [31:0] snap0, snap1;
    ram[0] = 32'hCAFE0123; ram[1] = 32'h0BADF00D;
    snap0 = ram[0]; snap1 = ram[1];
    t[0] = '{1'b0, 2'b10, 1'b0, 32'h6,    32'h0,        1'b1, 32'h0, 1, 0};
    t[1] = '{1'b1, 2'b01, 1'b0, 32'h3,    32'h0000FFFF, 1'b1, 32'h0, 1, 0};
    t[2] = '{1'b1, 2'b11, 1'b0, 32'h4,    32'hFFFFFFFF, 1'b1, 32'h0, 1, 0};
    t[3] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0, 1, 0};
    foreach (t[i]) begin
      sb.push_back(t[i]);
      run_req(t[i], rd, er, lat, wes, cl);
      e = sb.pop_front();
      total++; if (er !== e.err) begin bad++; $display("FAIL error[%0d] err got=%b exp=%b", i, er, e.err); end
      total++; if (rd !== e.rdata) begin bad++; $display("FAIL error[%0d] rdata got=%h exp=%h", i, rd, e.rdata); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL error[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
      total++; if (wes !== e.wes) begin bad++; $display("FAIL error[%0d] we_cycles got=%0d exp=%0d", i, wes, e.wes); end
      total++; if (cl !== 1'b1) begin bad++; $display("FAIL error[%0d] pulse_clear got=%b exp=1", i, cl); end
    end
    total++; if (ram[0] !== snap0) begin bad++; $display("FAIL error ram0 got=%h exp=%h", ram[0], snap0); end
    total++; if (ram[1] !== snap1) begin bad++; $display("FAIL error ram1 got=%h exp=%h", ram[1], snap1); end
  endtask

  task automatic test_reset_mid_write;
    req_t r;
    ram[8] = 32'h11111111;
    r = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h00000055, 1'b0, 32'h0, 2, 1};
    @(negedge clk);
    drive(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_wr mem_we_before got=%b exp=1", mem_we); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_wr mem_we_async got=%b exp=0", mem_we); end
    @(negedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    total++; if (ram[8] !== 32'h11111111) begin bad++; $display("FAIL rst_wr ram got=%h exp=11111111", ram[8]); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL rst_wr idle[%0d] resp_valid=%b req_ready=%b exp 0/1", k, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    req_t a, b, e;
    int cyc;
    a = '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'h80F1AA04, 2, 0};
    b = '{1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 1'b0, 32'hFFFFFFF1, 2, 0};
    @(negedge clk);
    drive(a); sb.push_back(a);
    @(posedge clk); #1;
    drive(b); sb.push_back(b);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b ready_busy got=%b exp=0", req_ready); end
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      if (resp_valid === 1'b1) begin
        e = sb.pop_front();
        total++; if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          bad++; $display("FAIL b2b resp rdata=%h err=%b exp rdata=%h err=%b", resp_rdata, resp_err, e.rdata, e.err);
        end
        if (sb.size() == 1) req_valid = 1'b1;
      end
      if (req_ready === 1'b1 && sb.size() == 0) req_valid = 1'b0;
      @(posedge clk); #1;
      if (sb.size() == 0) req_valid = 1'b0;
      cyc++;
    end
    req_valid = 1'b0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b timeout pending got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
